dly_catch_fifo: RTL
===================

// Module: dly_catch_fifo
// PURPOSE
//  Catch buffer at the output of a fixed-latency delayN pipeline (delay1..delay5).
//  The pipeline has clock enable only and no back-pressure, so the items in flight
//  when the consumer stalls land here. issue_ok tells the upstream issuer when it
//  may launch a new item so that those in-flight items never overflow the buffer.
//  First-word-fall-through FIFO with a valid/ready output handshake.
// PARAMETERS
//  WID    1   data width in bits; ports use the [WID:1] form
//  DEPTH  8   number of FIFO entries; power of 2; must satisfy DEPTH >= LAT+2
//  LAT    5   register stages between the issue point and port i (5 for delay5)
// PORTS
//  clk      in   1                  clock; all state updates on the rising edge
//  rst      in   1                  synchronous reset, active-high
//  ce       in   1                  clock enable; tie to the same ce as the delay line
//  i_vld    in   1                  item present on i; valid bit carried through the delay line
//  i        in   WID                data from the delay line output
//  issue_ok out  1                  upstream may issue a new item this cycle
//  o_vld    out  1                  head entry valid
//  o_rdy    in   1                  consumer accepts the head entry
//  o        out  WID                head entry data; forced to 0 when o_vld=0
//  count    out  $clog2(DEPTH+1)    current occupancy, 0..DEPTH
//  ovf      out  1                  sticky overflow flag
// BEHAVIOUR
//  - Reset: rst has priority over ce. It clears wr_ptr, rd_ptr, count and ovf.
//    After reset: o_vld=0, o=0, count=0, ovf=0, issue_ok=1.
//    Memory contents are not cleared.
//  - Reset mid-operation discards all stored entries. In-flight items arriving
//    after reset are accepted normally.
//  - ce=0: no pointer, count or flag change; i_vld and o_rdy are ignored.
//    All outputs hold and reflect the current state.
//  - Write: wr = ce & i_vld & (~full | rd). On a write, mem[wr_ptr] <= i and wr_ptr
//    increments, wrapping modulo DEPTH.
//  - Read: rd = ce & o_vld & o_rdy. On a read, rd_ptr increments, wrapping modulo DEPTH.
//  - Flags: full = (count==DEPTH); o_vld = (count!=0).
//  - count: next = count + wr - rd.
//  - Full with simultaneous read and write: both are accepted and count stays DEPTH.
//  - Empty with a write: no read is possible that cycle. The data becomes visible on
//    o with o_vld=1 in the cycle after the write edge, so latency from i to o is 1 clock.
//  - Output path is FWFT: o = o_vld ? mem[rd_ptr] : 0 (combinational read).
//    Handshake: the entry transfers on any ce edge with o_vld & o_rdy.
//    o_vld never drops without a transfer. o is stable while o_vld=1 and the head
//    has not been read.
//  - Overflow: ce & i_vld & full & ~rd drops the item (no state change other than
//    the flag) and sets ovf=1 on that edge. ovf clears only on rst.
//  - issue_ok = (count <= DEPTH-LAT-1), combinational from count.
//    Guarantee: if the upstream issues only when issue_ok=1 (ce-qualified), ovf can
//    never set, even with o_rdy held low indefinitely. Worst case is LAT uncounted
//    items in flight plus the new one.
//  - Width rules: count is $clog2(DEPTH+1) bits; pointers are $clog2(DEPTH) bits.
//    issue_ok is compared at count width and never underflows given DEPTH >= LAT+2.
//  - Elaboration error if DEPTH is not a power of 2 or DEPTH < LAT+2.
// TESTING  (WID=8, DEPTH=8, LAT=5 unless noted)
//  1 Reset, then write A1,A2,A3 on 3 cycles with o_rdy=0 -> count=1,2,3.
//    issue_ok=1 at count<=2 and 0 at count=3. o=A1, o_vld=1 from the cycle after the A1 write.
//  2 Hold o_rdy=1 and stream 0x10..0x1F with i_vld=1 -> o presents 0x10..0x1F in order,
//    1 clock after each write. count stays <=1, ovf=0.
//  3 Fill to count=8, then i_vld=1 and o_rdy=1 on the same edge -> both accepted.
//    count stays 8, order preserved, ovf=0.
//  4 Full, o_rdy=0, write 0xEE -> 0xEE dropped, ovf=1 and sticky.
//    Draining yields the original 8 entries. ovf clears only after rst.
//  5 Issuer model obeys issue_ok with ce toggled randomly and o_rdy random (1000 items)
//    -> ovf=0 throughout, output sequence equals input sequence.
//    While ce=0, all outputs hold.
//  6 With count=5, assert rst for 1 cycle concurrent with i_vld=1 and o_rdy=1
//    -> next cycle count=0, o_vld=0, o=0, issue_ok=1. The item presented during rst is dropped.

Source files
------------

// File: rtl/dly_catch_fifo.sv
// ---------------------------------------------------------------------------
// dly_catch_fifo
//
// Catch buffer for the output of a fixed-latency delay line (delay1..delay5).
// The delay line has a clock enable and no back-pressure. When the consumer
// stalls, the items already in flight have to land somewhere, and this buffer
// holds them. issue_ok throttles the upstream issuer so that those in-flight
// items always fit.
//
// The output side is a first-word-fall-through FIFO with a valid/ready
// handshake. The head entry is visible on o as soon as it is stored.
//
// Parameters
//   WID    data width in bits (ports use the [WID:1] form)
//   DEPTH  number of entries; must be a power of 2 and >= LAT+2
//   LAT    register stages between the issue point and port i
//
// Ports
//   clk       clock; all state updates on the rising edge
//   rst       synchronous reset, active-high; has priority over ce
//   ce        clock enable shared with the delay line
//   i_vld     item present on i (valid bit carried through the delay line)
//   i         data from the delay line output
//   issue_ok  upstream may issue a new item this cycle
//   o_vld     head entry valid
//   o_rdy     consumer accepts the head entry
//   o         head entry data; 0 when o_vld is low
//   count     current occupancy, 0..DEPTH
//   ovf       sticky overflow flag; cleared only by rst
// ---------------------------------------------------------------------------
module dly_catch_fifo #(
    parameter int WID   = 1,
    parameter int DEPTH = 8,
    parameter int LAT   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       i_vld,
    input  logic [WID:1]               i,
    output logic                       issue_ok,
    output logic                       o_vld,
    input  logic                       o_rdy,
    output logic [WID:1]               o,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int CW = $clog2(DEPTH + 1);  // occupancy width, holds 0..DEPTH
    localparam int PW = $clog2(DEPTH);      // pointer width, wraps modulo DEPTH

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    // The issuer may launch while occupancy leaves room for LAT uncounted
    // in-flight items plus the new one.
    localparam logic [CW-1:0] ISSUE_LIMIT = CW'(DEPTH - LAT - 1);

    // -----------------------------------------------------------------------
    // Parameter checks at elaboration time
    // -----------------------------------------------------------------------
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2
            $error("dly_catch_fifo: DEPTH must be a power of 2");
        end
        if (DEPTH < LAT + 2) begin : g_depth_lat
            $error("dly_catch_fifo: DEPTH must be >= LAT+2");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Storage and state
    // -----------------------------------------------------------------------
    logic [WID:1]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          full;
    logic          wr;
    logic          rd;
    logic          drop;
    logic [CW-1:0] count_nxt;

    // -----------------------------------------------------------------------
    // Handshake decode and next occupancy
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        full      = (count == DEPTH_C);
        o_vld     = (count != '0);
        rd        = ce & o_vld & o_rdy;
        // A full buffer can still take a write when the head leaves on the
        // same edge, so occupancy stays at DEPTH.
        wr        = ce & i_vld & (~full | rd);
        drop      = ce & i_vld & full & ~rd;
        count_nxt = count;
        if (wr && !rd) begin
            count_nxt = count + CW'(1);
        end else if (rd && !wr) begin
            count_nxt = count - CW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Pointer, occupancy and flag registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            // With ce low, wr, rd and drop are all 0, so everything holds.
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset. Stale contents are never observable because
    // o is masked by o_vld, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= i;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Fall-through read: the head entry is visible as soon as it is stored.
    assign o        = o_vld ? mem[rd_ptr] : '0;
    assign issue_ok = (count <= ISSUE_LIMIT);

endmodule
